// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port plus outgoing valid/ready stream of fifo_rd_stream.
// Signal names keep the adapter's point of view (_o driven by the adapter, _i driven by its neighbours).
interface fifo_rd_stream_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LEN_WIDTH = 16
);
  logic                 fifo_rd_en_o;
  logic [WIDTH-1:0]     fifo_rd_data_i;
  logic                 fifo_rd_empty_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [WIDTH-1:0]     out_data_o;
  logic                 out_last_o;
  logic [LEN_WIDTH-1:0] frame_len_i;

  // Adapter side
  modport master (
    output fifo_rd_en_o,
    input  fifo_rd_data_i,
    input  fifo_rd_empty_i,
    output out_valid_o,
    input  out_ready_i,
    output out_data_o,
    output out_last_o,
    input  frame_len_i
  );

  // Environment side: upstream FIFO and downstream sink
  modport slave (
    input  fifo_rd_en_o,
    output fifo_rd_data_i,
    output fifo_rd_empty_i,
    input  out_valid_o,
    output out_ready_i,
    input  out_data_o,
    input  out_last_o,
    output frame_len_i
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a registered-read FIFO into a valid/ready stream through a
// 3-entry skid buffer, sustaining one word per cycle into a ready sink.
// Optional frame marking (out_last_o) is built when FIFO_RD_STREAM_LAST_EN is defined.
module fifo_rd_stream #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  fifo_rd_stream_if.master bus
);

  localparam int unsigned DEPTH = 3;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned LVL_W = 3;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic [LVL_W-1:0] level_c;
  logic             capture_c;
  logic             pop_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Words held plus the one in flight; reads stop once that reaches DEPTH
  assign level_c   = LVL_W'(occ_q) + LVL_W'(inflight_q);
  assign capture_c = inflight_q;
  assign pop_c     = bus.out_valid_o & bus.out_ready_i;

  assign bus.fifo_rd_en_o = rst_n_i & ~bus.fifo_rd_empty_i & (level_c < LVL_W'(DEPTH));
  assign bus.out_valid_o  = (occ_q != '0);
  assign bus.out_data_o   = mem_q[rd_ptr_q];

  // Buffer write, pointer and occupancy update
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    inflight_d = bus.fifo_rd_en_o;
    for (int i = 0; i < int'(DEPTH); i++) mem_d[i] = mem_q[i];
    if (capture_c) begin
      mem_d[wr_ptr_q] = bus.fifo_rd_data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_c) rd_ptr_d = ptr_inc(rd_ptr_q);
    occ_d = occ_q + PTR_W'(capture_c) - PTR_W'(pop_c);
  end

  // Buffer state registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
    end
  end

`ifdef FIFO_RD_STREAM_LAST_EN
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                 last_c;

  assign last_c = bus.out_valid_o & (bus.frame_len_i != '0) &
                  (beat_cnt_q == bus.frame_len_i - LEN_WIDTH'(1));
  assign bus.out_last_o = last_c;

  // Beat counter: counts pops, restarts after the last beat of a frame
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (pop_c) beat_cnt_d = last_c ? '0 : beat_cnt_q + LEN_WIDTH'(1);
  end

  // Beat counter register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) beat_cnt_q <= '0;
    else          beat_cnt_q <= beat_cnt_d;
  end
`else
  logic unused_frame_len;

  assign unused_frame_len = ^bus.frame_len_i;
  assign bus.out_last_o   = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: randomized and directed bench; an upstream FIFO model feeds the DUT
// and a word-order scoreboard plus frame-position model checks the stream.
module tb_fifo_rd_stream;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned LEN_WIDTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  fifo_rd_stream_if #(.WIDTH(WIDTH), .LEN_WIDTH(LEN_WIDTH)) bus ();

  fifo_rd_stream #(.WIDTH(WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] fq[$];     // upstream FIFO contents
  logic [WIDTH-1:0] exp_q[$];  // words the sink still has to receive, in order
  int  rd_cnt, pop_cnt, pop_idx, last_cnt, flen;
  bit  ready_nxt;
  bit  hold;
  logic [WIDTH-1:0] hold_data;
  logic hold_last;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
  endtask

  function automatic bit exp_last_now();
`ifdef FIFO_RD_STREAM_LAST_EN
    if (flen == 0) return 1'b0;
    return (pop_idx % flen) == (flen - 1);
`else
    return 1'b0;
`endif
  endfunction

  // Negedge checks: read legality, held-word bound, handshake stability, scoreboard
  task automatic monitor();
    check_eq("rd_when_empty", 32'(bus.fifo_rd_en_o & bus.fifo_rd_empty_i), 32'd0);
    check_eq("held_over_3", 32'((rd_cnt - pop_cnt) > 3), 32'd0);
    if (hold) begin
      check_eq("hold_valid", 32'(bus.out_valid_o), 32'd1);
      check_eq("hold_data", 32'(bus.out_data_o), 32'(hold_data));
      check_eq("hold_last", 32'(bus.out_last_o), 32'(hold_last));
    end
    if (bus.out_valid_o) begin
      check_eq("last", 32'(bus.out_last_o), 32'(exp_last_now()));
      if (bus.out_ready_i) begin
        if (exp_q.size() == 0) check_eq("unexpected_pop", 32'd1, 32'd0);
        else check_eq("pop_data", 32'(bus.out_data_o), 32'(exp_q.pop_front()));
        if (bus.out_last_o) last_cnt++;
        pop_idx++;
        pop_cnt++;
      end
    end else begin
      check_eq("last_idle", 32'(bus.out_last_o), 32'd0);
    end
    hold      = bus.out_valid_o & ~bus.out_ready_i;
    hold_data = bus.out_data_o;
    hold_last = bus.out_last_o;
  endtask

  // One clock: FIFO model reacts to the edge, inputs change #1 later, checks at negedge
  task automatic step();
    bit took;
    @(posedge clk);
    took = bus.fifo_rd_en_o && !bus.fifo_rd_empty_i;
    #1;
    if (took) begin
      bus.fifo_rd_data_i = fq.pop_front();
      rd_cnt++;
    end
    bus.fifo_rd_empty_i = (fq.size() == 0);
    bus.out_ready_i     = ready_nxt;
    @(negedge clk);
    monitor();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    fq.delete();
    exp_q.delete();
    rd_cnt  = 0;
    pop_cnt = 0;
    pop_idx = 0;
    hold    = 1'b0;
    bus.fifo_rd_empty_i = 1'b0;
    #1;
    check_eq("rst_rd_en", 32'(bus.fifo_rd_en_o), 32'd0);
    check_eq("rst_valid", 32'(bus.out_valid_o), 32'd0);
    check_eq("rst_data", 32'(bus.out_data_o), 32'd0);
    check_eq("rst_last", 32'(bus.out_last_o), 32'd0);
    bus.fifo_rd_empty_i = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int budget);
    int c;
    ready_nxt = 1'b1;
    c = 0;
    while ((exp_q.size() != 0 || bus.out_valid_o) && c < budget) begin
      step();
      c++;
    end
    check_eq("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int r0, l0, n, c;
    bus.fifo_rd_empty_i = 1'b1;
    bus.fifo_rd_data_i  = '0;
    bus.out_ready_i     = 1'b0;
    bus.frame_len_i     = '0;
    ready_nxt = 1'b0;
    flen      = 0;
    last_cnt  = 0;
    #2;
    apply_reset();

    // First word: read request in the cycle empty falls, valid two cycles later
    ready_nxt = 1'b0;
    push(8'hA5);
    step();
    check_eq("first_rd_en", 32'(bus.fifo_rd_en_o), 32'd1);
    check_eq("first_valid_n", 32'(bus.out_valid_o), 32'd0);
    step();
    check_eq("first_valid_n1", 32'(bus.out_valid_o), 32'd0);
    step();
    check_eq("first_valid_n2", 32'(bus.out_valid_o), 32'd1);
    check_eq("first_data", 32'(bus.out_data_o), 32'hA5);
    drain(20);

    // Streaming: 16 bubble-free beats, then idle
    ready_nxt = 1'b1;
    for (int i = 0; i < 16; i++) push(WIDTH'(i));
    c = 0;
    do begin
      step();
      c++;
    end while (!bus.out_valid_o && c < 10);
    for (int i = 0; i < 16; i++) begin
      check_eq("stream_valid", 32'(bus.out_valid_o), 32'd1);
      step();
    end
    check_eq("stream_idle", 32'(bus.out_valid_o), 32'd0);
    check_eq("stream_left", 32'(exp_q.size()), 32'd0);

    // Backpressure: only 3 reads while stalled, word 0 presented and held
    ready_nxt = 1'b0;
    step();
    r0 = rd_cnt;
    for (int i = 0; i < 8; i++) push(WIDTH'(8'h80 + i));
    repeat (10) step();
    check_eq("bp_reads", 32'(rd_cnt - r0), 32'd3);
    check_eq("bp_valid", 32'(bus.out_valid_o), 32'd1);
    check_eq("bp_data", 32'(bus.out_data_o), 32'h80);
    drain(100);

    // Random words against random ready
    n = 0;
    c = 0;
    while ((n < 1000 || exp_q.size() != 0 || bus.out_valid_o) && c < 20000) begin
      if (n < 1000 && $urandom_range(0, 1) == 1) begin
        push(WIDTH'($urandom));
        n++;
      end
      ready_nxt = ($urandom_range(0, 1) == 1);
      step();
      c++;
    end
    check_eq("rand_pushed", 32'(n), 32'd1000);
    check_eq("rand_left", 32'(exp_q.size()), 32'd0);
    check_eq("rand_no_last", 32'(last_cnt), 32'd0);

    // Reset with the buffer full and stalled
    ready_nxt = 1'b0;
    for (int i = 0; i < 6; i++) push(WIDTH'(8'h40 + i));
    repeat (6) step();
    check_eq("pre_rst_held", 32'(rd_cnt - pop_cnt), 32'd3);
    check_eq("pre_rst_valid", 32'(bus.out_valid_o), 32'd1);
    #2;
    apply_reset();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    drain(50);
    check_eq("post_rst_pops", 32'(pop_cnt), 32'd3);

    // Framing: length 4 over 10 words, from a fresh reset so the beat count starts at 0
    #2;
    apply_reset();
    flen = 4;
    bus.frame_len_i = LEN_WIDTH'(flen);
    l0 = last_cnt;
    for (int i = 0; i < 10; i++) push(WIDTH'(8'hC0 + i));
    drain(60);
`ifdef FIFO_RD_STREAM_LAST_EN
    check_eq("frame_lasts", 32'(last_cnt - l0), 32'd2);
`else
    check_eq("frame_lasts", 32'(last_cnt - l0), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
